// File: rtl/riscv_pkg.sv
// Shared RV32I opcode constants, dispatch-class encoding and immediate
// extraction helpers used by the issue/dispatch stage.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    CLS_ROB = 2'd0,
    CLS_RS  = 2'd1,
    CLS_LSB = 2'd2
  } cls_e;

  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/issue_decode.sv
// Combinational RV32I decoder for the queue head: dispatch class, register
// fields, sign-extended immediate and the LUI/AUIPC precomputed result.
module issue_decode
  import riscv_pkg::*;
(
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  output cls_e        cls_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic        funct7b5_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [31:0] imm_o,
  output logic [31:0] value_o,
  output logic        illegal_o
);

  assign opcode_o   = inst_i[6:0];
  assign funct3_o   = inst_i[14:12];
  assign funct7b5_o = inst_i[30];
  assign rs1_o      = inst_i[19:15];
  assign rs2_o      = inst_i[24:20];

  always_comb begin
    cls_o     = CLS_ROB;
    rd_o      = inst_i[11:7];
    imm_o     = '0;
    value_o   = '0;
    illegal_o = 1'b0;
    unique case (inst_i[6:0])
      OP_LUI: begin
        imm_o   = imm_u(inst_i);
        value_o = imm_u(inst_i);
      end
      OP_AUIPC: begin
        imm_o   = imm_u(inst_i);
        value_o = pc_i + imm_u(inst_i);
      end
      OP_JAL: begin
        cls_o = CLS_RS;
        imm_o = imm_j(inst_i);
      end
      OP_JALR, OP_IMM: begin
        cls_o = CLS_RS;
        imm_o = imm_i(inst_i);
      end
      OP_BRANCH: begin
        cls_o = CLS_RS;
        rd_o  = '0;
        imm_o = imm_b(inst_i);
      end
      OP_REG: begin
        cls_o = CLS_RS;
      end
      OP_LOAD: begin
        cls_o = CLS_LSB;
        imm_o = imm_i(inst_i);
      end
      OP_STORE: begin
        cls_o = CLS_LSB;
        rd_o  = '0;
        imm_o = imm_s(inst_i);
      end
      default: begin
        // Unknown opcodes still retire through the ROB so the fault is precise.
        rd_o      = '0;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/issue_dispatch_queue.sv
// Circular instruction queue with in-order single-issue dispatch to the
// ROB / RS / LSB, fetch headroom, flush and global-ready freeze.
module issue_dispatch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SKID  = 1,
  parameter int ROB_W = 5
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     fetch_valid_in,
  input  logic [31:0]              fetch_inst_in,
  input  logic [31:0]              fetch_pc_in,
  output logic                     fetch_ready_out,
  input  logic                     rob_full_in,
  input  logic                     rs_full_in,
  input  logic                     lsb_full_in,
  input  logic [ROB_W-1:0]         rob_tail_id_in,
  output logic                     disp_valid_out,
  output logic                     disp_to_rs_out,
  output logic                     disp_to_lsb_out,
  output logic [6:0]               disp_opcode_out,
  output logic [2:0]               disp_funct3_out,
  output logic                     disp_funct7b5_out,
  output logic [4:0]               disp_rd_out,
  output logic [4:0]               disp_rs1_out,
  output logic [4:0]               disp_rs2_out,
  output logic [31:0]              disp_imm_out,
  output logic [31:0]              disp_pc_out,
  output logic [31:0]              disp_value_out,
  output logic [ROB_W-1:0]         disp_rob_id_out,
  output logic                     disp_illegal_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic        not_empty;
  logic        not_full;
  logic        push;
  logic        pop;
  logic        blocked;

  cls_e        dec_cls;
  logic [6:0]  dec_opcode;
  logic [2:0]  dec_funct3;
  logic        dec_funct7b5;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [31:0] dec_imm;
  logic [31:0] dec_value;
  logic        dec_illegal;
  logic [31:0] head_inst;
  logic [31:0] head_pc;

  assign not_empty       = (count_q != '0);
  assign not_full        = (count_q < CNT_W'(DEPTH));
  assign fetch_ready_out = (count_q < CNT_W'(DEPTH - SKID));
  assign count_out       = count_q;
  assign disp_rob_id_out = rob_tail_id_in;

  assign head_inst = inst_mem[head_q];
  assign head_pc   = pc_mem[head_q];

  issue_decode u_decode (
    .inst_i     (head_inst),
    .pc_i       (head_pc),
    .cls_o      (dec_cls),
    .opcode_o   (dec_opcode),
    .funct3_o   (dec_funct3),
    .funct7b5_o (dec_funct7b5),
    .rd_o       (dec_rd),
    .rs1_o      (dec_rs1),
    .rs2_o      (dec_rs2),
    .imm_o      (dec_imm),
    .value_o    (dec_value),
    .illegal_o  (dec_illegal)
  );

  // Only the units the head instruction actually needs can stall it.
  always_comb begin
    blocked = rob_full_in;
    if (dec_cls == CLS_RS && rs_full_in)   blocked = 1'b1;
    if (dec_cls == CLS_LSB && lsb_full_in) blocked = 1'b1;
  end

  assign pop  = not_empty && rdy_in && !flush_in && !blocked;
  assign push = rdy_in && !flush_in && fetch_valid_in && not_full;

  assign disp_valid_out  = pop;
  assign disp_to_rs_out  = pop && (dec_cls == CLS_RS);
  assign disp_to_lsb_out = pop && (dec_cls == CLS_LSB);

  // Storage is not reset, so decode is masked while the queue is empty.
  assign disp_opcode_out   = not_empty ? dec_opcode   : '0;
  assign disp_funct3_out   = not_empty ? dec_funct3   : '0;
  assign disp_funct7b5_out = not_empty ? dec_funct7b5 : 1'b0;
  assign disp_rd_out       = not_empty ? dec_rd       : '0;
  assign disp_rs1_out      = not_empty ? dec_rs1      : '0;
  assign disp_rs2_out      = not_empty ? dec_rs2      : '0;
  assign disp_imm_out      = not_empty ? dec_imm      : '0;
  assign disp_pc_out       = not_empty ? head_pc      : '0;
  assign disp_value_out    = not_empty ? dec_value    : '0;
  assign disp_illegal_out  = not_empty ? dec_illegal  : 1'b0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in) begin
      if (flush_in) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);
        unique case ({push, pop})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      inst_mem[tail_q] <= fetch_inst_in;
      pc_mem[tail_q]   <= fetch_pc_in;
    end
  end

endmodule

// File: tb/tb_issue_dispatch_queue.sv
// Directed bench for issue_dispatch_queue: vector table for the dispatch
// stream plus hand-written fill, flush and rdy freeze sequences.
module tb_issue_dispatch_queue;

  localparam logic [31:0] I_ADDI  = 32'hFFF00093; // addi x1,x0,-1
  localparam logic [31:0] I_SW    = 32'hFE512E23; // sw x5,-4(x2)
  localparam logic [31:0] I_LUI   = 32'h12345137; // lui x2,0x12345
  localparam logic [31:0] I_AUIPC = 32'h80000197; // auipc x3,0x80000
  localparam logic [31:0] I_LW    = 32'h0000A203; // lw x4,0(x1)
  localparam logic [31:0] I_ADD   = 32'h002082B3; // add x5,x1,x2
  localparam logic [31:0] I_BEQ   = 32'hFE208CE3; // beq x1,x2,-8
  localparam logic [31:0] I_JAL   = 32'hFFDFF06F; // jal x0,-4
  localparam logic [31:0] I_ILL   = 32'h0000050B; // custom-0, rd=x10

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        fv;
  logic [31:0] finst;
  logic [31:0] fpc;
  logic        fready;
  logic        robf, rsf, lsbf;
  logic [4:0]  rob_tail;
  logic        dvld, drs, dlsb;
  logic [6:0]  dopc;
  logic [2:0]  df3;
  logic        df7;
  logic [4:0]  drd, drs1, drs2;
  logic [31:0] dimm, dpc, dval;
  logic [4:0]  drob;
  logic        dill;
  logic [4:0]  cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  issue_dispatch_queue #(.DEPTH(16), .SKID(1), .ROB_W(5)) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .rdy_in            (rdy),
    .flush_in          (flush),
    .fetch_valid_in    (fv),
    .fetch_inst_in     (finst),
    .fetch_pc_in       (fpc),
    .fetch_ready_out   (fready),
    .rob_full_in       (robf),
    .rs_full_in        (rsf),
    .lsb_full_in       (lsbf),
    .rob_tail_id_in    (rob_tail),
    .disp_valid_out    (dvld),
    .disp_to_rs_out    (drs),
    .disp_to_lsb_out   (dlsb),
    .disp_opcode_out   (dopc),
    .disp_funct3_out   (df3),
    .disp_funct7b5_out (df7),
    .disp_rd_out       (drd),
    .disp_rs1_out      (drs1),
    .disp_rs2_out      (drs2),
    .disp_imm_out      (dimm),
    .disp_pc_out       (dpc),
    .disp_value_out    (dval),
    .disp_rob_id_out   (drob),
    .disp_illegal_out  (dill),
    .count_out         (cnt)
  );

  typedef struct {
    logic        fv;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        robf, rsf, lsbf;
    logic [4:0]  cnt;
    logic        vld, rs, lsb;
    logic        dec;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] val;
    logic        ill;
  } vec_t;

  vec_t tv [18];

  function automatic vec_t mk(logic f, logic [31:0] i, logic [31:0] p,
                              logic ro, logic rs_, logic ls, logic [4:0] c,
                              logic v, logic r, logic l, logic d,
                              logic [4:0] rdv, logic [31:0] im,
                              logic [31:0] vl, logic il);
    vec_t t;
    t.fv = f; t.inst = i; t.pc = p; t.robf = ro; t.rsf = rs_; t.lsbf = ls;
    t.cnt = c; t.vld = v; t.rs = r; t.lsb = l; t.dec = d;
    t.rd = rdv; t.imm = im; t.val = vl; t.ill = il;
    return t;
  endfunction

  function automatic logic [31:0] addi(int k);
    logic [31:0] w;
    w = {20'd0, 12'h000} | 32'h00000093;
    w[31:20] = k[11:0];
    return w;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(logic f, logic [31:0] i, logic [31:0] p,
                     logic ro, logic rs_, logic ls);
    rdy = 1'b1; flush = 1'b0;
    fv = f; finst = i; fpc = p; robf = ro; rsf = rs_; lsbf = ls;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rob_tail = 5'd9;
    drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    tv[0]  = mk(1, I_ADDI,  32'h1000, 0,0,0, 5'd0, 0,0,0, 0, 5'd0, 32'h0, 32'h0, 0);
    tv[1]  = mk(1, I_SW,    32'h1004, 0,0,0, 5'd1, 1,1,0, 1, 5'd1, 32'hFFFFFFFF, 32'h0, 0);
    tv[2]  = mk(1, I_LUI,   32'h1008, 0,0,0, 5'd1, 1,0,1, 1, 5'd0, 32'hFFFFFFFC, 32'h0, 0);
    tv[3]  = mk(1, I_AUIPC, 32'h80000010, 0,0,0, 5'd1, 1,0,0, 1, 5'd2, 32'h12345000, 32'h12345000, 0);
    tv[4]  = mk(0, 32'h0,   32'h0,    0,0,0, 5'd1, 1,0,0, 1, 5'd3, 32'h80000000, 32'h00000010, 0);
    tv[5]  = mk(1, I_LW,    32'h2000, 0,0,1, 5'd0, 0,0,0, 0, 5'd0, 32'h0, 32'h0, 0);
    tv[6]  = mk(1, I_ADD,   32'h2004, 0,0,1, 5'd1, 0,0,0, 1, 5'd4, 32'h0, 32'h0, 0);
    tv[7]  = mk(0, 32'h0,   32'h0,    0,0,1, 5'd2, 0,0,0, 1, 5'd4, 32'h0, 32'h0, 0);
    tv[8]  = mk(0, 32'h0,   32'h0,    0,0,0, 5'd2, 1,0,1, 1, 5'd4, 32'h0, 32'h0, 0);
    tv[9]  = mk(0, 32'h0,   32'h0,    0,0,0, 5'd1, 1,1,0, 1, 5'd5, 32'h0, 32'h0, 0);
    tv[10] = mk(1, I_BEQ,   32'h3000, 1,0,0, 5'd0, 0,0,0, 0, 5'd0, 32'h0, 32'h0, 0);
    tv[11] = mk(1, I_JAL,   32'h3004, 1,0,0, 5'd1, 0,0,0, 1, 5'd0, 32'hFFFFFFF8, 32'h0, 0);
    tv[12] = mk(1, I_ILL,   32'h3008, 0,1,0, 5'd2, 0,0,0, 1, 5'd0, 32'hFFFFFFF8, 32'h0, 0);
    tv[13] = mk(0, 32'h0,   32'h0,    0,0,1, 5'd3, 1,1,0, 1, 5'd0, 32'hFFFFFFF8, 32'h0, 0);
    tv[14] = mk(0, 32'h0,   32'h0,    0,1,1, 5'd2, 0,0,0, 1, 5'd0, 32'hFFFFFFFC, 32'h0, 0);
    tv[15] = mk(0, 32'h0,   32'h0,    0,0,0, 5'd2, 1,1,0, 1, 5'd0, 32'hFFFFFFFC, 32'h0, 0);
    tv[16] = mk(0, 32'h0,   32'h0,    0,1,1, 5'd1, 1,0,0, 1, 5'd0, 32'h0, 32'h0, 1);
    tv[17] = mk(0, 32'h0,   32'h0,    0,0,0, 5'd0, 0,0,0, 0, 5'd0, 32'h0, 32'h0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count",  32'(cnt),    32'd0);
    chk("rst_valid",  32'(dvld),   32'd0);
    chk("rst_imm",    dimm,        32'd0);
    chk("rst_opcode", 32'(dopc),   32'd0);
    chk("rst_ready",  32'(fready), 32'd1);
    chk("rst_robid",  32'(drob),   32'd9);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven dispatch stream
    for (int k = 0; k < 18; k++) begin
      drv(tv[k].fv, tv[k].inst, tv[k].pc, tv[k].robf, tv[k].rsf, tv[k].lsbf);
      @(negedge clk);
      chk($sformatf("v%0d_count", k), 32'(cnt),  32'(tv[k].cnt));
      chk($sformatf("v%0d_valid", k), 32'(dvld), 32'(tv[k].vld));
      chk($sformatf("v%0d_to_rs", k), 32'(drs),  32'(tv[k].rs));
      chk($sformatf("v%0d_to_lsb", k), 32'(dlsb), 32'(tv[k].lsb));
      if (tv[k].dec) begin
        chk($sformatf("v%0d_rd", k),  32'(drd), 32'(tv[k].rd));
        chk($sformatf("v%0d_imm", k), dimm,     tv[k].imm);
        chk($sformatf("v%0d_val", k), dval,     tv[k].val);
        chk($sformatf("v%0d_ill", k), 32'(dill), 32'(tv[k].ill));
      end
      next_cycle();
    end

    // Fill to full with the ROB stalled; headroom drops at 15
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, addi(i), 32'h4000 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("fill%0d_ready", i), 32'(fready), (i < 15) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d_count", i), 32'(cnt), 32'(i));
      next_cycle();
    end
    drv(1'b1, addi(99), 32'h5000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_count", 32'(cnt),    32'd16);
    chk("full_ready", 32'(fready), 32'd0);
    chk("full_valid", 32'(dvld),   32'd1);
    chk("full_imm",   dimm,        32'd0);
    next_cycle();
    drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_count", i), 32'(cnt), 32'(16 - i));
      chk($sformatf("drain%0d_imm", i),   dimm,      32'(i));
      chk($sformatf("drain%0d_pc", i),    dpc,       32'h4000 + 32'(i * 4));
      next_cycle();
    end
    @(negedge clk);
    chk("drain_end_count", 32'(cnt),  32'd0);
    chk("drain_end_valid", 32'(dvld), 32'd0);
    next_cycle();

    // Flush with 7 queued and a simultaneous push
    for (int i = 0; i < 7; i++) begin
      drv(1'b1, addi(20 + i), 32'h6000, 1'b1, 1'b0, 1'b0);
      next_cycle();
    end
    drv(1'b1, addi(50), 32'h6100, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_count", 32'(cnt),  32'd7);
    chk("flush_valid", 32'(dvld), 32'd0);
    chk("flush_to_rs", 32'(drs),  32'd0);
    next_cycle();
    drv(1'b1, addi(5), 32'h6200, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("postflush_count", 32'(cnt),  32'd0);
    chk("postflush_valid", 32'(dvld), 32'd0);
    next_cycle();
    drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("postflush_push_valid", 32'(dvld), 32'd1);
    chk("postflush_push_imm",   dimm,      32'd5);
    chk("postflush_push_pc",    dpc,       32'h6200);
    next_cycle();
    @(negedge clk);
    chk("postflush_empty", 32'(cnt), 32'd0);

    // rdy_in freeze for 4 cycles with pushes (and a flush) offered
    for (int i = 1; i <= 3; i++) begin
      drv(1'b1, addi(i), 32'h7000, 1'b1, 1'b0, 1'b0);
      next_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, addi(4), 32'h7100, 1'b0, 1'b0, 1'b0);
      rdy = 1'b0;
      flush = (i == 2);
      @(negedge clk);
      chk($sformatf("frz%0d_count", i), 32'(cnt),  32'd3);
      chk($sformatf("frz%0d_valid", i), 32'(dvld), 32'd0);
      chk($sformatf("frz%0d_to_rs", i), 32'(drs),  32'd0);
      chk($sformatf("frz%0d_imm", i),   dimm,      32'd1);
      next_cycle();
    end
    drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("resume%0d_valid", i), 32'(dvld), 32'd1);
      chk($sformatf("resume%0d_imm", i),   dimm,      32'(i));
      next_cycle();
    end
    @(negedge clk);
    chk("resume_end_count", 32'(cnt),  32'd0);
    chk("resume_end_valid", 32'(dvld), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
